// File: rtl/hazard_unit_pkg.sv
// Shared types for the pipeline hazard/sequencing controller.
package hazard_unit_pkg;

    typedef logic [4:0] regbits_t;

    typedef enum logic [1:0] {
        RUN,
        MEMWAIT,
        HALTED
    } hz_state_t;

    // Per-cycle pipeline control; first member is the MSB.
    typedef struct packed {
        logic pc_en;
        logic if_id_en;
        logic id_ex_en;
        logic ex_mem_en;
        logic mem_wb_en;
        logic if_id_flush;
        logic id_ex_flush;
        logic ex_mem_flush;
    } hz_ctrl_t;

    localparam hz_ctrl_t CTRL_NONE    = hz_ctrl_t'(8'b0000_0000);
    localparam hz_ctrl_t CTRL_ADV     = hz_ctrl_t'(8'b1111_1000);
    localparam hz_ctrl_t CTRL_REDIR   = hz_ctrl_t'(8'b1111_1111);
    // PC and IF/ID hold, a bubble goes into EX, the load moves on to MEM.
    localparam hz_ctrl_t CTRL_LOADUSE = hz_ctrl_t'(8'b0001_1010);
    // Fetch not back yet: hold PC, push a bubble into ID, drain the rest.
    localparam hz_ctrl_t CTRL_NOFETCH = hz_ctrl_t'(8'b0111_1100);
    // Let the halt instruction retire, freeze everything else.
    localparam hz_ctrl_t CTRL_HALT    = hz_ctrl_t'(8'b0000_1000);

    function automatic logic is_dwait(logic dren, logic dwen, logic dhit);
        return (dren | dwen) & ~dhit;
    endfunction

endpackage

// File: rtl/hazard_unit_if.sv
// Hazard unit signal bundle: hu is the block side, tb the driving side.
interface hazard_unit_if #(
    parameter int CNT_W = 32
);
    import hazard_unit_pkg::*;

    logic             ihit;
    logic             dhit;
    regbits_t         id_rs;
    regbits_t         id_rt;
    logic             id_uses_rt;
    logic             ex_dREN;
    regbits_t         ex_dest;
    logic             mem_dREN;
    logic             mem_dWEN;
    logic             mem_redirect;
    logic             mem_halt;

    logic             pc_en;
    logic             if_id_en;
    logic             id_ex_en;
    logic             ex_mem_en;
    logic             mem_wb_en;
    logic             if_id_flush;
    logic             id_ex_flush;
    logic             ex_mem_flush;
    logic             halt;
    logic             mem_timeout;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_count;

    modport hu (
        input  ihit, dhit, id_rs, id_rt, id_uses_rt, ex_dREN, ex_dest,
               mem_dREN, mem_dWEN, mem_redirect, mem_halt,
        output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
               if_id_flush, id_ex_flush, ex_mem_flush,
               halt, mem_timeout, stall_cycles, flush_count
    );

    modport tb (
        output ihit, dhit, id_rs, id_rt, id_uses_rt, ex_dREN, ex_dest,
               mem_dREN, mem_dWEN, mem_redirect, mem_halt,
        input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
               if_id_flush, id_ex_flush, ex_mem_flush,
               halt, mem_timeout, stall_cycles, flush_count
    );

endinterface

// File: rtl/hazard_unit_loaduse_detect.sv
// Load-use detector: a load in EX whose destination is a source of the
// instruction in ID cannot be forwarded in time. $0 never creates a hazard.
module hazard_unit_loaduse_detect
    import hazard_unit_pkg::*;
(
    input  logic     ex_dREN,
    input  regbits_t ex_dest,
    input  regbits_t id_rs,
    input  regbits_t id_rt,
    input  logic     id_uses_rt,
    output logic     loaduse
);

    assign loaduse = ex_dREN && (ex_dest != '0) &&
                     ((ex_dest == id_rs) || (id_uses_rt && (ex_dest == id_rt)));

endmodule

// File: rtl/hazard_unit.sv
// Pipeline sequencing controller: per-cycle advance/hold/flush for the PC and
// the four pipeline latches, plus stall/flush counters and a D-cache watchdog.
module hazard_unit
    import hazard_unit_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 1024
) (
    input  logic     CLK,
    input  logic     nRST,
    hazard_unit_if.hu hif
);

    localparam int WT_W = $clog2(MEM_TIMEOUT + 1);

    hz_state_t        state, state_n;
    hz_ctrl_t         run_ctrl, ctrl;
    logic             loaduse, dwait;
    logic             run_sel, wait_inc, wait_clr, stall_inc, flush_inc;
    logic [WT_W-1:0]  wait_q;
    logic             timeout_q;
    logic [CNT_W-1:0] stall_q, flush_q;

    hazard_unit_loaduse_detect u_loaduse (
        .ex_dREN    (hif.ex_dREN),
        .ex_dest    (hif.ex_dest),
        .id_rs      (hif.id_rs),
        .id_rt      (hif.id_rt),
        .id_uses_rt (hif.id_uses_rt),
        .loaduse    (loaduse)
    );

    assign dwait = is_dwait(hif.mem_dREN, hif.mem_dWEN, hif.dhit);

    // Normal-flow priority once memory is not blocking: redirect, load-use, fetch miss.
    always_comb begin
        run_ctrl = CTRL_ADV;
        if (hif.mem_redirect)
            run_ctrl = CTRL_REDIR;
        else if (loaduse)
            run_ctrl = CTRL_LOADUSE;
        else if (!hif.ihit)
            run_ctrl = CTRL_NOFETCH;
    end

    // Next state and zero-latency pipeline controls; halt beats a memory wait.
    always_comb begin
        state_n  = state;
        ctrl     = CTRL_NONE;
        run_sel  = 1'b0;
        wait_inc = 1'b0;
        wait_clr = 1'b0;
        case (state)
            RUN: begin
                if (hif.mem_halt) begin
                    ctrl    = CTRL_HALT;
                    state_n = HALTED;
                end else if (dwait) begin
                    wait_inc = 1'b1;
                    state_n  = MEMWAIT;
                end else begin
                    run_sel = 1'b1;
                end
            end
            MEMWAIT: begin
                if (!hif.dhit) begin
                    wait_inc = 1'b1;
                end else begin
                    wait_clr = 1'b1;
                    if (hif.mem_halt) begin
                        ctrl    = CTRL_HALT;
                        state_n = HALTED;
                    end else begin
                        run_sel = 1'b1;
                        state_n = RUN;
                    end
                end
            end
            HALTED:  state_n = HALTED;
            default: state_n = RUN;
        endcase
        if (run_sel)
            ctrl = run_ctrl;
        // Nothing may move while reset is held.
        if (!nRST)
            ctrl = CTRL_NONE;
    end

    assign stall_inc = ~ctrl.pc_en & (state != HALTED);
    assign flush_inc = run_sel & hif.mem_redirect;

    // State register.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)
            state <= RUN;
        else
            state <= state_n;
    end

    // Watchdog: count consecutive D-cache wait cycles, flag sticky once the limit is hit.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wait_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (wait_clr)
                wait_q <= '0;
            else if (wait_inc && (wait_q != WT_W'(MEM_TIMEOUT)))
                wait_q <= wait_q + 1'b1;
            if (wait_inc && (wait_q == WT_W'(MEM_TIMEOUT - 1)))
                timeout_q <= 1'b1;
        end
    end

    // Saturating performance counters.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (stall_inc && (stall_q != '1))
                stall_q <= stall_q + 1'b1;
            if (flush_inc && (flush_q != '1))
                flush_q <= flush_q + 1'b1;
        end
    end

    assign hif.pc_en        = ctrl.pc_en;
    assign hif.if_id_en     = ctrl.if_id_en;
    assign hif.id_ex_en     = ctrl.id_ex_en;
    assign hif.ex_mem_en    = ctrl.ex_mem_en;
    assign hif.mem_wb_en    = ctrl.mem_wb_en;
    assign hif.if_id_flush  = ctrl.if_id_flush;
    assign hif.id_ex_flush  = ctrl.id_ex_flush;
    assign hif.ex_mem_flush = ctrl.ex_mem_flush;
    assign hif.halt         = (state == HALTED);
    assign hif.mem_timeout  = timeout_q;
    assign hif.stall_cycles = stall_q;
    assign hif.flush_count  = flush_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit (small counter / watchdog build).
module tb_hazard_unit;
    import hazard_unit_pkg::*;

    localparam int CNT_W       = 4;
    localparam int MEM_TIMEOUT = 4;

    // Expected control vectors: {pc,if_id,id_ex,ex_mem,mem_wb en, if_id,id_ex,ex_mem flush}
    localparam logic [7:0] E_ZERO    = 8'h00;
    localparam logic [7:0] E_ADV     = 8'hF8;
    localparam logic [7:0] E_REDIR   = 8'hFF;
    localparam logic [7:0] E_NOFETCH = 8'h7C;
    localparam logic [7:0] E_LU      = 8'h1A;
    localparam logic [7:0] E_HALT    = 8'h08;
    localparam logic [7:0] M_ALL     = 8'hFF;
    localparam logic [7:0] M_LU      = 8'hDF;   // id_ex_en is a don't-care during the bubble

    typedef struct {
        logic [7:0] val;
        logic [7:0] mask;
        string      tag;
    } exp_t;

    logic CLK  = 1'b0;
    logic nRST = 1'b0;
    always #5 CLK = ~CLK;

    hazard_unit_if #(.CNT_W(CNT_W)) hif ();

    hazard_unit #(.CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .hif  (hif)
    );

    logic [7:0] outv;
    assign outv = {hif.pc_en, hif.if_id_en, hif.id_ex_en, hif.ex_mem_en, hif.mem_wb_en,
                   hif.if_id_flush, hif.id_ex_flush, hif.ex_mem_flush};

    exp_t sbq[$];
    exp_t e;
    int   total = 0;
    int   bad   = 0;

    task automatic idle_in();
        hif.ihit = 1'b1; hif.dhit = 1'b0;
        hif.id_rs = '0; hif.id_rt = '0; hif.id_uses_rt = 1'b0;
        hif.ex_dREN = 1'b0; hif.ex_dest = '0;
        hif.mem_dREN = 1'b0; hif.mem_dWEN = 1'b0;
        hif.mem_redirect = 1'b0; hif.mem_halt = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        nRST = 1'b0;
        idle_in();
        @(negedge CLK);
        nRST = 1'b1;
    endtask

    task automatic test_reset();
        idle_in();
        @(negedge CLK);
        sbq.push_back('{E_ZERO, M_ALL, "reset_outs"});
        #1;
        e = sbq.pop_front(); total++;
        if ((outv & e.mask) !== e.val) begin
            bad++; $display("FAIL %s: got %b want %b", e.tag, outv & e.mask, e.val);
        end
        total++;
        if ({hif.halt, hif.mem_timeout, hif.stall_cycles, hif.flush_count} !== '0) begin
            bad++; $display("FAIL reset_state: got halt=%b to=%b st=%0d fl=%0d want all 0",
                            hif.halt, hif.mem_timeout, hif.stall_cycles, hif.flush_count);
        end
        @(negedge CLK);
        nRST = 1'b1;
        sbq.push_back('{E_ADV, M_ALL, "reset_release"});
        #1;
        e = sbq.pop_front(); total++;
        if ((outv & e.mask) !== e.val) begin
            bad++; $display("FAIL %s: got %b want %b", e.tag, outv & e.mask, e.val);
        end
    endtask

    task automatic test_loaduse();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            idle_in();
            hif.ex_dREN = 1'b1;
            case (i)
                0: begin hif.ex_dest = 5'd8; hif.id_rs = 5'd8;
                         sbq.push_back('{E_LU, M_LU, "loaduse_rs"}); end
                1: begin hif.ex_dest = 5'd0; hif.id_rs = 5'd0;
                         sbq.push_back('{E_ADV, M_ALL, "loaduse_r0"}); end
                2: begin hif.ex_dest = 5'd9; hif.id_rt = 5'd9; hif.id_uses_rt = 1'b1;
                         sbq.push_back('{E_LU, M_LU, "loaduse_rt"}); end
                3: begin hif.ex_dest = 5'd9; hif.id_rt = 5'd9; hif.id_uses_rt = 1'b0;
                         sbq.push_back('{E_ADV, M_ALL, "loaduse_rt_unused"}); end
                default: begin hif.ex_dREN = 1'b0; hif.ex_dest = 5'd8; hif.id_rs = 5'd8;
                         sbq.push_back('{E_ADV, M_ALL, "no_load"}); end
            endcase
            #1;
            e = sbq.pop_front(); total++;
            if ((outv & e.mask) !== e.val) begin
                bad++; $display("FAIL %s: got %b want %b", e.tag, outv & e.mask, e.val);
            end
        end
        @(negedge CLK);
        idle_in();
        total++;
        if (hif.stall_cycles !== 4'd2) begin
            bad++; $display("FAIL loaduse_stalls: got %0d want 2", hif.stall_cycles);
        end
    endtask

    task automatic test_memwait();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            idle_in();
            hif.mem_dREN = (i < 4);
            hif.dhit     = (i == 3);
            sbq.push_back('{(i < 3) ? E_ZERO : E_ADV, M_ALL, "memwait"});
            #1;
            e = sbq.pop_front(); total++;
            if ((outv & e.mask) !== e.val) begin
                bad++; $display("FAIL %s[%0d]: got %b want %b", e.tag, i, outv & e.mask, e.val);
            end
            if (i == 3) begin
                @(negedge CLK);
                total++;
                if (hif.stall_cycles !== 4'd3 || hif.mem_timeout !== 1'b0) begin
                    bad++; $display("FAIL memwait_count: got st=%0d to=%b want st=3 to=0",
                                    hif.stall_cycles, hif.mem_timeout);
                end
            end
        end
    endtask

    task automatic test_timeout();
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            idle_in();
            hif.mem_dWEN = 1'b1;
            hif.dhit     = (i == 4);
            sbq.push_back('{(i < 4) ? E_ZERO : E_ADV, M_ALL, "timeout_wait"});
            #1;
            e = sbq.pop_front(); total++;
            if ((outv & e.mask) !== e.val) begin
                bad++; $display("FAIL %s[%0d]: got %b want %b", e.tag, i, outv & e.mask, e.val);
            end
        end
        @(negedge CLK);
        idle_in();
        total++;
        if (hif.mem_timeout !== 1'b1 || hif.stall_cycles !== 4'd7) begin
            bad++; $display("FAIL timeout_set: got to=%b st=%0d want to=1 st=7",
                            hif.mem_timeout, hif.stall_cycles);
        end
        repeat (3) @(negedge CLK);
        total++;
        if (hif.mem_timeout !== 1'b1) begin
            bad++; $display("FAIL timeout_sticky: got %b want 1", hif.mem_timeout);
        end
    endtask

    task automatic test_redirect();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            idle_in();
            case (i)
                0: begin hif.mem_redirect = 1'b1; hif.ihit = 1'b0;
                         hif.ex_dREN = 1'b1; hif.ex_dest = 5'd8; hif.id_rs = 5'd8;
                         sbq.push_back('{E_REDIR, M_ALL, "redirect_override"}); end
                1: begin hif.mem_redirect = 1'b1; hif.mem_dREN = 1'b1;
                         sbq.push_back('{E_ZERO, M_ALL, "redirect_dwait"}); end
                2: begin hif.mem_redirect = 1'b1; hif.mem_dREN = 1'b1; hif.dhit = 1'b1;
                         sbq.push_back('{E_REDIR, M_ALL, "redirect_on_dhit"}); end
                default: begin hif.ihit = 1'b0;
                         sbq.push_back('{E_NOFETCH, M_ALL, "ihit_miss"}); end
            endcase
            #1;
            e = sbq.pop_front(); total++;
            if ((outv & e.mask) !== e.val) begin
                bad++; $display("FAIL %s: got %b want %b", e.tag, outv & e.mask, e.val);
            end
            if (i == 0) begin
                @(posedge CLK); #1;
                total++;
                if (hif.flush_count !== 4'd1) begin
                    bad++; $display("FAIL flush_count_1: got %0d want 1", hif.flush_count);
                end
            end
        end
        @(negedge CLK);
        idle_in();
        total++;
        if (hif.flush_count !== 4'd2 || hif.stall_cycles !== 4'd2) begin
            bad++; $display("FAIL redirect_counts: got fl=%0d st=%0d want fl=2 st=2",
                            hif.flush_count, hif.stall_cycles);
        end
    endtask

    task automatic test_saturate();
        do_reset();
        for (int i = 0; i < 16; i++) begin
            @(negedge CLK);
            idle_in();
            hif.ihit = 1'b0;
            sbq.push_back('{E_NOFETCH, M_ALL, "sat_nofetch"});
            #1;
            e = sbq.pop_front(); total++;
            if ((outv & e.mask) !== e.val) begin
                bad++; $display("FAIL %s[%0d]: got %b want %b", e.tag, i, outv & e.mask, e.val);
            end
            if (i >= 14) begin
                @(posedge CLK); #1;
                total++;
                if (hif.stall_cycles !== 4'd15) begin
                    bad++; $display("FAIL stall_saturate[%0d]: got %0d want 15", i, hif.stall_cycles);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            idle_in();
            hif.mem_dREN = 1'b1;
            sbq.push_back('{E_ZERO, M_ALL, "mid_wait"});
            #1;
            e = sbq.pop_front(); total++;
            if ((outv & e.mask) !== e.val) begin
                bad++; $display("FAIL %s[%0d]: got %b want %b", e.tag, i, outv & e.mask, e.val);
            end
        end
        @(negedge CLK);
        total++;
        if (hif.stall_cycles !== 4'd5) begin
            bad++; $display("FAIL mid_stalls: got %0d want 5", hif.stall_cycles);
        end
        #2;
        idle_in();
        nRST = 1'b0;
        sbq.push_back('{E_ZERO, M_ALL, "reset_mid_outs"});
        #1;
        e = sbq.pop_front(); total++;
        if ((outv & e.mask) !== e.val) begin
            bad++; $display("FAIL %s: got %b want %b", e.tag, outv & e.mask, e.val);
        end
        total++;
        if (hif.stall_cycles !== 4'd0 || hif.flush_count !== 4'd0) begin
            bad++; $display("FAIL reset_mid_counters: got st=%0d fl=%0d want 0",
                            hif.stall_cycles, hif.flush_count);
        end
        @(negedge CLK);
        nRST = 1'b1;
        sbq.push_back('{E_ADV, M_ALL, "reset_mid_run"});
        #1;
        e = sbq.pop_front(); total++;
        if ((outv & e.mask) !== e.val) begin
            bad++; $display("FAIL %s: got %b want %b", e.tag, outv & e.mask, e.val);
        end
    endtask

    task automatic test_halt();
        do_reset();
        @(negedge CLK);
        idle_in();
        hif.mem_halt = 1'b1;
        hif.mem_dREN = 1'b1;
        sbq.push_back('{E_HALT, M_ALL, "halt_entry"});
        #1;
        e = sbq.pop_front(); total++;
        if ((outv & e.mask) !== e.val) begin
            bad++; $display("FAIL %s: got %b want %b", e.tag, outv & e.mask, e.val);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            idle_in();
            hif.ihit = i[0];
            hif.dhit = ~i[0];
            hif.mem_redirect = 1'b1;
            hif.mem_dREN = i[1];
            sbq.push_back('{E_ZERO, M_ALL, "halted"});
            #1;
            e = sbq.pop_front(); total++;
            if ((outv & e.mask) !== e.val || hif.halt !== 1'b1) begin
                bad++; $display("FAIL %s[%0d]: got %b halt=%b want %b halt=1",
                                e.tag, i, outv & e.mask, hif.halt, e.val);
            end
        end
        total++;
        if (hif.stall_cycles !== 4'd1 || hif.flush_count !== 4'd0) begin
            bad++; $display("FAIL halt_counters: got st=%0d fl=%0d want st=1 fl=0",
                            hif.stall_cycles, hif.flush_count);
        end
    endtask

    initial begin
        test_reset();
        test_loaduse();
        test_memwait();
        test_timeout();
        test_redirect();
        test_saturate();
        test_reset_mid();
        test_halt();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
